// File: rtl/e_mdu_param_if.sv
// Handshake/bus bundle between the E stage and the
// parametrised multiply/divide unit.
interface e_mdu_param_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       mduOp;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             start;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mduOp, d1, d2, start, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  mduOp, d1, d2, start, cancel,
    output busy, hi, lo
  );
endinterface

// File: rtl/e_mdu_param.sv
// Parametrised MIPS multiply/divide unit with HI/LO,
// fixed-latency busy interlock and flush cancel.
module e_mdu_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  e_mdu_param_if.slave mdu
);

  localparam int W2   = 2 * WIDTH;
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;

  logic [W2-1:0]    d1_s, d2_s, d1_u, d2_u;
  logic [W2-1:0]    prod_s, prod_u, hilo;
  logic             neg_a, neg_b, div0;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] qu, ru, qm, rm, qs, rs;
  logic             accept;

  // Sign-extend to 2W so one unsigned multiplier
  // gives the correct low 2W bits for signed ops.
  assign d1_s   = {{WIDTH{mdu.d1[WIDTH-1]}}, mdu.d1};
  assign d2_s   = {{WIDTH{mdu.d2[WIDTH-1]}}, mdu.d2};
  assign d1_u   = {{WIDTH{1'b0}}, mdu.d1};
  assign d2_u   = {{WIDTH{1'b0}}, mdu.d2};
  assign prod_s = d1_s * d2_s;
  assign prod_u = d1_u * d2_u;
  assign hilo   = {hi_q, lo_q};

  assign neg_a = mdu.d1[WIDTH-1];
  assign neg_b = mdu.d2[WIDTH-1];
  assign a_mag = neg_a ? -mdu.d1 : mdu.d1;
  assign b_mag = neg_b ? -mdu.d2 : mdu.d2;
  assign div0  = (mdu.d2 == '0);

  always_comb begin
    qu = '0;
    ru = '0;
    qm = '0;
    rm = '0;
    if (!div0) begin
      qu = mdu.d1 / mdu.d2;
      ru = mdu.d1 % mdu.d2;
      qm = a_mag / b_mag;
      rm = a_mag % b_mag;
    end
  end

  // MIN / -1 falls out as MIN with remainder 0.
  assign qs = (neg_a ^ neg_b) ? -qm : qm;
  assign rs = neg_a ? -rm : rm;

  assign accept = mdu.start & ~mdu.cancel &
                  (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (mdu.mduOp)
            OP_MULT, OP_MULTU,
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: begin
              state_d = RUN;
              cnt_d   = CW'(MULT_CYCLES);
              case (mdu.mduOp)
                OP_MULT:  {phi_d, plo_d} = prod_s;
                OP_MULTU: {phi_d, plo_d} = prod_u;
                OP_MADD:  {phi_d, plo_d} = hilo + prod_s;
                OP_MADDU: {phi_d, plo_d} = hilo + prod_u;
                OP_MSUB:  {phi_d, plo_d} = hilo - prod_s;
                default:  {phi_d, plo_d} = hilo - prod_u;
              endcase
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = CW'(DIV_CYCLES);
              if (div0) begin
                {phi_d, plo_d} = hilo;
              end else if (mdu.mduOp == OP_DIV) begin
                {phi_d, plo_d} = {rs, qs};
              end else begin
                {phi_d, plo_d} = {ru, qu};
              end
            end
            OP_MTHI: hi_d = mdu.d1;
            OP_MTLO: lo_d = mdu.d1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (mdu.cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = phi_q;
          lo_d    = plo_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign mdu.busy = (state_q == RUN);
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu_param.sv
// Bench for e_mdu_param: 32-bit default and a
// 16-bit/1/3-cycle instance against an arithmetic model.
module tb_e_mdu_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  e_mdu_param_if #(.WIDTH(32)) m32 ();
  e_mdu_param_if #(.WIDTH(16)) m16 ();

  e_mdu_param #(
    .WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)
  ) dut32 (
    .clk(clk), .reset(reset), .mdu(m32.slave)
  );

  e_mdu_param #(
    .WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)
  ) dut16 (
    .clk(clk), .reset(reset), .mdu(m16.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  longint unsigned mh [2];
  longint unsigned ml [2];

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic longint unsigned mask(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(longint unsigned v, int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // HI/LO semantics straight from the ISA definitions.
  function automatic void ref_op(
    input int w, input int op,
    input longint unsigned a, input longint unsigned b,
    inout longint unsigned h, inout longint unsigned l);
    longint unsigned m, p, acc;
    longint sa, sb;
    m   = mask(w);
    sa  = sx(a, w);
    sb  = sx(b, w);
    acc = (h << w) | l;
    case (op)
      1, 7, 9:  p = longint'(sa * sb);
      2, 8, 10: p = a * b;
      default:  p = 0;
    endcase
    case (op)
      1, 2: begin h = (p >> w) & m; l = p & m; end
      7, 8: begin
        acc = acc + p; h = (acc >> w) & m; l = acc & m;
      end
      9, 10: begin
        acc = acc - p; h = (acc >> w) & m; l = acc & m;
      end
      3: if (b != 0) begin
        l = longint'(sa / sb) & m;
        h = longint'(sa % sb) & m;
      end
      4: if (b != 0) begin
        l = (a / b) & m; h = (a % b) & m;
      end
      5: h = a;
      6: l = a;
      default: ;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(bit s, int op, longint unsigned a,
                     longint unsigned b, bit st, bit cn);
    if (s) begin
      m16.mduOp = 4'(op); m16.d1 = 16'(a); m16.d2 = 16'(b);
      m16.start = st; m16.cancel = cn;
    end else begin
      m32.mduOp = 4'(op); m32.d1 = 32'(a); m32.d2 = 32'(b);
      m32.start = st; m32.cancel = cn;
    end
  endtask

  task automatic ctl(bit s, bit st, bit cn);
    if (s) begin m16.start = st; m16.cancel = cn; end
    else begin m32.start = st; m32.cancel = cn; end
  endtask

  function automatic logic bsy(bit s);
    return s ? m16.busy : m32.busy;
  endfunction

  function automatic logic [63:0] hi_of(bit s);
    return s ? {48'b0, m16.hi} : {32'b0, m32.hi};
  endfunction

  function automatic logic [63:0] lo_of(bit s);
    return s ? {48'b0, m16.lo} : {32'b0, m32.lo};
  endfunction

  task automatic go(bit s, int op, longint unsigned a,
                    longint unsigned b, int cancel_at,
                    int restart_at, string tag);
    int w, n, expn;
    bit hold_ok;
    logic [63:0] ph, pl;
    longint unsigned eh, el;
    w = s ? 16 : 32;
    a = a & mask(w);
    b = b & mask(w);
    if (op inside {1, 2, 7, 8, 9, 10}) expn = s ? 1 : 5;
    else if (op inside {3, 4}) expn = s ? 3 : 10;
    else expn = 0;
    eh = mh[s];
    el = ml[s];
    ref_op(w, op, a, b, eh, el);
    if (cancel_at >= 1 && cancel_at <= expn) begin
      expn = cancel_at;
      eh = mh[s];
      el = ml[s];
    end
    ph = hi_of(s);
    pl = lo_of(s);
    set(s, op, a, b, 1'b1, 1'b0);
    cyc();
    set(s, 0, $urandom, $urandom, 1'b0, 1'b0);
    n = bsy(s) ? 1 : 0;
    hold_ok = 1'b1;
    while (bsy(s) && n < 64) begin
      if (hi_of(s) !== ph || lo_of(s) !== pl) hold_ok = 1'b0;
      if (n == restart_at)
        set(s, 1, $urandom, $urandom, 1'b1, 1'b0);
      if (n == cancel_at) ctl(s, 1'b0, 1'b1);
      cyc();
      ctl(s, 1'b0, 1'b0);
      if (bsy(s)) n++;
    end
    chk({tag, "/busy"}, 64'(n), 64'(expn));
    chk({tag, "/hi"}, hi_of(s), eh);
    chk({tag, "/lo"}, lo_of(s), el);
    if (expn > 0) chk({tag, "/hold"}, 64'(hold_ok), 64'd1);
    mh[s] = eh;
    ml[s] = el;
  endtask

  initial begin
    int n, op, ca;
    longint unsigned a, b;
    mh[0] = 0; ml[0] = 0; mh[1] = 0; ml[1] = 0;
    set(0, 0, 0, 0, 1'b0, 1'b0);
    set(1, 0, 0, 0, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("rst/busy", 64'(m32.busy), 64'd0);
    chk("rst/hi", hi_of(0), 64'd0);
    chk("rst/lo", lo_of(0), 64'd0);
    chk("rst16/busy", 64'(m16.busy), 64'd0);
    reset = 1'b1;
    cyc();

    go(0, 1, 64'hFFFFFFFF, 2, 0, 0, "mult");
    chk("mult/hi_c", hi_of(0), 64'hFFFFFFFF);
    chk("mult/lo_c", lo_of(0), 64'hFFFFFFFE);
    go(0, 2, 64'hFFFFFFFF, 2, 0, 0, "multu");
    chk("multu/hi_c", hi_of(0), 64'h1);
    go(0, 3, 64'hFFFFFFF9, 2, 0, 0, "div");
    chk("div/lo_c", lo_of(0), 64'hFFFFFFFD);
    chk("div/hi_c", hi_of(0), 64'hFFFFFFFF);
    go(0, 4, 64'hFFFFFFF9, 2, 0, 0, "divu");
    chk("divu/lo_c", lo_of(0), 64'h7FFFFFFC);
    go(0, 3, 64'h80000000, 64'hFFFFFFFF, 0, 0, "divmin");
    chk("divmin/lo_c", lo_of(0), 64'h80000000);
    chk("divmin/hi_c", hi_of(0), 64'h0);
    go(0, 3, 64'h12345678, 0, 0, 0, "div0");
    go(0, 4, 64'h9ABCDEF0, 0, 0, 0, "divu0");
    go(0, 5, 0, 0, 0, 0, "mthi");
    go(0, 6, 64'hFFFFFFFF, 0, 0, 0, "mtlo");
    go(0, 8, 1, 1, 0, 0, "maddu");
    chk("maddu/hi_c", hi_of(0), 64'h1);
    chk("maddu/lo_c", lo_of(0), 64'h0);
    go(0, 9, 1, 2, 0, 0, "msub");
    chk("msub/hi_c", hi_of(0), 64'h0);
    chk("msub/lo_c", lo_of(0), 64'hFFFFFFFE);

    go(0, 1, 64'h1234, 64'h5678, 0, 2, "interlock");
    go(0, 1, 64'hDEAD, 64'hBEEF, 3, 0, "cancel3");
    go(0, 2, 64'hCAFE, 64'hF00D, 5, 0, "cancellast");
    go(0, 4, 64'h777, 64'h5, 10, 0, "cancellastdiv");

    set(0, 5, 64'hA5A5A5A5, 0, 1'b1, 1'b1);
    cyc();
    set(0, 0, 0, 0, 1'b0, 1'b0);
    chk("idlecancel/hi", hi_of(0), 64'(mh[0]));
    chk("idlecancel/busy", 64'(m32.busy), 64'd0);

    go(0, 1, 64'h00010001, 64'h00020002, 0, 0, "prediv");
    set(0, 3, 64'h7654321, 64'h13, 1'b1, 1'b0);
    cyc();
    set(0, 0, 0, 0, 1'b0, 1'b0);
    n = 1;
    repeat (3) begin
      cyc();
      if (m32.busy) n++;
    end
    chk("rstmid/pre", 64'(n), 64'd4);
    #2 reset = 1'b0;
    #1;
    chk("rstmid/busy", 64'(m32.busy), 64'd0);
    chk("rstmid/hi", hi_of(0), 64'd0);
    chk("rstmid/lo", lo_of(0), 64'd0);
    mh[0] = 0; ml[0] = 0; mh[1] = 0; ml[1] = 0;
    cyc();
    reset = 1'b1;
    cyc();
    go(0, 1, 64'hFFFF0003, 64'h7, 0, 0, "postrst");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 15);
      a = ($urandom_range(0, 5) == 0) ? 64'h80000000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 64'(0) :
          ($urandom_range(0, 5) == 0) ? 64'hFFFFFFFF :
          $urandom;
      ca = $urandom_range(0, 14);
      go(0, op, a, b, ca, 0, "rand32");
    end

    go(1, 1, 64'h8000, 64'h0002, 0, 0, "w16mult");
    chk("w16mult/hi_c", hi_of(1), 64'hFFFF);
    chk("w16mult/lo_c", lo_of(1), 64'h0000);
    go(1, 3, 64'h8000, 64'hFFFF, 0, 0, "w16divmin");
    chk("w16divmin/lo_c", lo_of(1), 64'h8000);
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 15);
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 64'(0) :
          64'($urandom);
      ca = $urandom_range(0, 5);
      go(1, op, a, b, ca, 0, "rand16");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
